// File: rtl/cmd_interp_fsm.sv
// Command-interpreter FSM for the two-operand calculator.
// Sequences key entry: two-digit A, operator, two-digit B, '='.
// Optional macro CMD_INTERP_CHAIN_EN: an operator key in RESULT starts a chained
// operation that reuses the result as operand A.
module cmd_interp_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       got_dig,
    input  logic       got_op,
    input  logic       got_eq,
    input  logic       got_esc,
    output logic       load_A1,
    output logic       load_A2,
    output logic       load_B1,
    output logic       load_B2,
    output logic       load_cmd,
    output logic       rdy,
    output logic [2:0] state_out
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        WAIT_A2 = 3'd1,
        WAIT_OP = 3'd2,
        WAIT_B1 = 3'd3,
        WAIT_B2 = 3'd4,
        WAIT_EQ = 3'd5,
        RESULT  = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register with synchronous reset to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, Mealy load strobes and Moore rdy
    always_comb begin
        state_d  = state_q;
        load_A1  = 1'b0;
        load_A2  = 1'b0;
        load_B1  = 1'b0;
        load_B2  = 1'b0;
        load_cmd = 1'b0;
        rdy      = 1'b0;

        if (state_q == RESULT) begin
            rdy = 1'b1;
        end

        if (got_esc) begin
            // Escape wins over every other key and issues no load
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (got_dig) begin
                        load_A1 = 1'b1;
                        state_d = WAIT_A2;
                    end
                end
                WAIT_A2: begin
                    if (got_dig) begin
                        load_A2 = 1'b1;
                        state_d = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (got_op) begin
                        load_cmd = 1'b1;
                        state_d  = WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (got_dig) begin
                        load_B1 = 1'b1;
                        state_d = WAIT_B2;
                    end
                end
                WAIT_B2: begin
                    if (got_dig) begin
                        load_B2 = 1'b1;
                        state_d = WAIT_EQ;
                    end
                end
                WAIT_EQ: begin
                    if (got_eq) begin
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    if (got_dig) begin
                        // New digit starts a fresh calculation
                        load_A1 = 1'b1;
                        state_d = WAIT_A2;
                    end
`ifdef CMD_INTERP_CHAIN_EN
                    else if (got_op) begin
                        // Chained operation: result stays as operand A
                        load_cmd = 1'b1;
                        state_d  = WAIT_B1;
                    end
`endif
                end
                default: begin
                    // Illegal code: recover to IDLE, all outputs quiet
                    state_d = IDLE;
                end
            endcase
        end

        // Loads are suppressed while reset is asserted
        if (rst) begin
            load_A1  = 1'b0;
            load_A2  = 1'b0;
            load_B1  = 1'b0;
            load_B2  = 1'b0;
            load_cmd = 1'b0;
        end
    end

    assign state_out = STATE_W'(state_q);

endmodule

// File: tb/tb_cmd_interp_fsm.sv
// Directed testbench for cmd_interp_fsm.
module tb_cmd_interp_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       got_dig, got_op, got_eq, got_esc;
    logic       load_A1, load_A2, load_B1, load_B2, load_cmd;
    logic       rdy;
    logic [2:0] state_out;

    int checks   = 0;
    int failures = 0;

    cmd_interp_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .got_dig  (got_dig),
        .got_op   (got_op),
        .got_eq   (got_eq),
        .got_esc  (got_esc),
        .load_A1  (load_A1),
        .load_A2  (load_A2),
        .load_B1  (load_B1),
        .load_B2  (load_B2),
        .load_cmd (load_cmd),
        .rdy      (rdy),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Loads packed as {A1, A2, cmd, B1, B2}
    localparam logic [4:0] L_NONE = 5'b00000;
    localparam logic [4:0] L_A1   = 5'b10000;
    localparam logic [4:0] L_A2   = 5'b01000;
    localparam logic [4:0] L_CMD  = 5'b00100;
    localparam logic [4:0] L_B1   = 5'b00010;
    localparam logic [4:0] L_B2   = 5'b00001;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of keys, check Mealy loads before the edge, state/rdy after it
    task automatic apply(input string tag, input logic d, input logic o, input logic e,
                         input logic x, input logic [4:0] exp_loads, input logic [2:0] exp_state);
        @(negedge clk);
        got_dig = d; got_op = o; got_eq = e; got_esc = x;
        #1;
        check({tag, ".loads"}, 32'({load_A1, load_A2, load_cmd, load_B1, load_B2}), 32'(exp_loads));
        @(posedge clk);
        #1;
        check({tag, ".state"}, 32'(state_out), 32'(exp_state));
        check({tag, ".rdy"}, 32'(rdy), 32'(exp_state == 3'd6));
    endtask

    task automatic idle(input string tag, input logic [2:0] exp_state);
        apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, L_NONE, exp_state);
    endtask

    // Full entry from IDLE to RESULT with idle cycles between keys
    task automatic run_to_result(input string tag);
        apply({tag, ".a1"}, 1'b1, 1'b0, 1'b0, 1'b0, L_A1, 3'd1);
        idle({tag, ".i1"}, 3'd1);
        apply({tag, ".a2"}, 1'b1, 1'b0, 1'b0, 1'b0, L_A2, 3'd2);
        idle({tag, ".i2"}, 3'd2);
        apply({tag, ".op"}, 1'b0, 1'b1, 1'b0, 1'b0, L_CMD, 3'd3);
        idle({tag, ".i3"}, 3'd3);
        apply({tag, ".b1"}, 1'b1, 1'b0, 1'b0, 1'b0, L_B1, 3'd4);
        idle({tag, ".i4"}, 3'd4);
        apply({tag, ".b2"}, 1'b1, 1'b0, 1'b0, 1'b0, L_B2, 3'd5);
        idle({tag, ".i5"}, 3'd5);
        apply({tag, ".eq"}, 1'b0, 1'b0, 1'b1, 1'b0, L_NONE, 3'd6);
    endtask

    initial begin
        rst = 1'b1;
        got_dig = 1'b1; got_op = 1'b0; got_eq = 1'b0; got_esc = 1'b0;

        // Reset for two cycles with a digit pending: loads must stay low
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("rst.loads", 32'({load_A1, load_A2, load_cmd, load_B1, load_B2}), 32'(L_NONE));
            @(posedge clk);
            #1;
            check("rst.state", 32'(state_out), 32'd0);
            check("rst.rdy", 32'(rdy), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        got_dig = 1'b0;
        idle("post_rst0", 3'd0);
        idle("post_rst1", 3'd0);

        // Unqualified keys in IDLE are ignored
        apply("idle_op_eq", 1'b0, 1'b1, 1'b1, 1'b0, L_NONE, 3'd0);

        // Full sequence
        run_to_result("seq");
        idle("seq.hold", 3'd6);

        // got_eq in RESULT changes nothing
        apply("res_eq", 1'b0, 1'b0, 1'b1, 1'b0, L_NONE, 3'd6);

        // Escape from RESULT drops rdy
        apply("res_esc", 1'b0, 1'b0, 1'b0, 1'b1, L_NONE, 3'd0);

        // Restart from RESULT with a digit
        run_to_result("seq2");
        apply("res_dig", 1'b1, 1'b0, 1'b0, 1'b0, L_A1, 3'd1);
        apply("esc_a2", 1'b0, 1'b0, 1'b0, 1'b1, L_NONE, 3'd0);

        // Held digit: two cycles high, two low, then high again
        apply("hold.d1", 1'b1, 1'b0, 1'b0, 1'b0, L_A1, 3'd1);
        apply("hold.d2", 1'b1, 1'b0, 1'b0, 1'b0, L_A2, 3'd2);
        idle("hold.i1", 3'd2);
        idle("hold.i2", 3'd2);
        apply("hold.d3", 1'b1, 1'b0, 1'b0, 1'b0, L_NONE, 3'd2);
        // Simultaneous digit and eq in WAIT_OP are both ignored
        apply("wop_dig_eq", 1'b1, 1'b0, 1'b1, 1'b0, L_NONE, 3'd2);

        // Escape together with a digit in WAIT_B2
        apply("e.op", 1'b0, 1'b1, 1'b0, 1'b0, L_CMD, 3'd3);
        apply("e.b1", 1'b1, 1'b0, 1'b0, 1'b0, L_B1, 3'd4);
        apply("e.esc_dig", 1'b1, 1'b0, 1'b0, 1'b1, L_NONE, 3'd0);

        // Optional chaining from RESULT
        run_to_result("seq3");
`ifdef CMD_INTERP_CHAIN_EN
        apply("res_op", 1'b0, 1'b1, 1'b0, 1'b0, L_CMD, 3'd3);
`else
        apply("res_op", 1'b0, 1'b1, 1'b0, 1'b0, L_NONE, 3'd6);
`endif
        apply("final_esc", 1'b0, 1'b0, 1'b0, 1'b1, L_NONE, 3'd0);

        // Reset mid-entry
        apply("r.a1", 1'b1, 1'b0, 1'b0, 1'b0, L_A1, 3'd1);
        @(negedge clk);
        rst = 1'b1; got_dig = 1'b1; got_esc = 1'b0;
        #1;
        check("midrst.loads", 32'({load_A1, load_A2, load_cmd, load_B1, load_B2}), 32'(L_NONE));
        @(posedge clk);
        #1;
        check("midrst.state", 32'(state_out), 32'd0);
        @(negedge clk);
        rst = 1'b0; got_dig = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
